// File: rtl/spi_slave_port_if.sv
// SPI responder pin and CPU-side bundle: serial pins plus transmit buffer and receive word.
// Latency: pure wiring, no state.
// Backpressure: none; tx_load is a strobe and rx_dv a pulse, neither side can stall.
interface spi_slave_port_if #(
  parameter int W = 32
);
  logic         sclk;
  logic         cs_n;
  logic         mosi;
  logic         miso;
  logic [W-1:0] tx_data;
  logic         tx_load;
  logic         tx_pending;
  logic [W-1:0] rx_data;
  logic         rx_dv;
  logic         tx_underrun;
  logic         frame_abort;

  // Responder side: pins and the CPU write strobe come in, status goes out.
  modport slave (
    input  sclk, cs_n, mosi, tx_data, tx_load,
    output miso, tx_pending, rx_data, rx_dv, tx_underrun, frame_abort
  );

  // Bus-master / CPU side: drives pins and the transmit word.
  modport master (
    output sclk, cs_n, mosi, tx_data, tx_load,
    input  miso, tx_pending, rx_data, rx_dv, tx_underrun, frame_abort
  );
endinterface

// File: rtl/spi_slave_port.sv
// SPI mode-0 responder: oversamples SCLK/CS_N/MOSI in clk, deserializes W-bit frames, serializes a buffered tx word.
// Latency: SYNC_STAGES+1 clk edges from a pin edge to the resulting action (rx_dv, miso shift, LOAD).
// Backpressure: none; a frame with no pending tx word sends zeros and pulses tx_underrun.
module spi_slave_port #(
  parameter int W           = 32,
  parameter int SYNC_STAGES = 2
) (
  input logic              clk,
  input logic              rst,
  spi_slave_port_if.slave  bus
);

  localparam int CNT_W = $clog2(W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_q;
  logic                   cs_q;

  logic sclk_s;
  logic cs_s;
  logic mosi_s;
  logic sclk_rise;
  logic sclk_fall;
  logic cs_fall;

  logic [W-1:0]     tx_buf;
  logic             tx_pending;
  logic [W-1:0]     tx_shift;
  logic             tx_underrun;
  logic [W-1:0]     rx_shift;
  logic [W-1:0]     rx_data;
  logic             rx_dv;
  logic [CNT_W-1:0] bit_cnt;
  logic             frame_end;
  logic             frame_abort;

  logic do_load;
  logic shift_active;
  logic abort_hit;

  // Pin synchronizers plus one extra stage for edge detection; CS resets deselected so no false fall after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
    end else begin
      if (SYNC_STAGES > 1) begin
        sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
        cs_sync   <= {cs_sync[SYNC_STAGES-2:0],   bus.cs_n};
        mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      end else begin
        sclk_sync[0] <= bus.sclk;
        cs_sync[0]   <= bus.cs_n;
        mosi_sync[0] <= bus.mosi;
      end
      sclk_q <= sclk_s;
      cs_q   <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign cs_fall   = ~cs_s & cs_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-cycle action decode; deselect overrides every SCLK edge.
  always_comb begin
    state_nxt    = state;
    do_load      = 1'b0;
    shift_active = 1'b0;
    abort_hit    = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) state_nxt = LOAD;
      end
      LOAD: begin
        do_load   = ~cs_s;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        shift_active = ~cs_s;
        if (sclk_fall && frame_end) state_nxt = LOAD;
        // A deselect is clean only right after the W-th rise, before its trailing fall.
        abort_hit = cs_s & ((bit_cnt != '0) | ~frame_end);
      end
      default: state_nxt = IDLE;
    endcase
    if (cs_s) state_nxt = IDLE;
  end

  // Transmit buffer: CPU writes land in any state; LOAD consumes the old word first, so a same-cycle write survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_buf      <= '0;
      tx_pending  <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      tx_underrun <= 1'b0;
      if (do_load) begin
        if (tx_pending) begin
          tx_pending <= 1'b0;
        end else begin
          tx_underrun <= 1'b1;
        end
      end
      if (bus.tx_load) begin
        tx_buf     <= bus.tx_data;
        tx_pending <= 1'b1;
      end
    end
  end

  // Transmit shifter: loaded in LOAD so the MSB is on miso before the first rise, advanced on each non-final fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_shift <= '0;
    end else if (do_load) begin
      tx_shift <= tx_pending ? tx_buf : '0;
    end else if (shift_active && sclk_fall && !frame_end) begin
      tx_shift <= tx_shift << 1;
    end
  end

  // Receive path: sample MOSI on rises, publish the word on the W-th rise, abort on a mid-frame deselect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_shift    <= '0;
      rx_data     <= '0;
      rx_dv       <= 1'b0;
      bit_cnt     <= '0;
      frame_end   <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      rx_dv       <= 1'b0;
      frame_abort <= 1'b0;
      if (cs_s) begin
        rx_shift    <= '0;
        bit_cnt     <= '0;
        frame_end   <= 1'b0;
        frame_abort <= abort_hit;
      end else if (shift_active) begin
        if (sclk_rise) begin
          rx_shift <= {rx_shift[W-2:0], mosi_s};
          if (bit_cnt == CNT_W'(W-1)) begin
            rx_data   <= {rx_shift[W-2:0], mosi_s};
            rx_dv     <= 1'b1;
            bit_cnt   <= '0;
            frame_end <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end else if (sclk_fall && frame_end) begin
          frame_end <= 1'b0;
        end
      end
    end
  end

  assign bus.miso        = (state == SHIFT) & ~cs_s & tx_shift[W-1];
  assign bus.tx_pending  = tx_pending;
  assign bus.rx_data     = rx_data;
  assign bus.rx_dv       = rx_dv;
  assign bus.tx_underrun = tx_underrun;
  assign bus.frame_abort = frame_abort;

endmodule

// File: tb/tb_spi_slave_port.sv
// Directed bench for spi_slave_port: drives SCLK/CS_N/MOSI as a mode-0 master, 8 clk per SCLK half-period.
// Latency: expectations assume SYNC_STAGES=2 (three clk edges from pin to action).
// Backpressure: not applicable; pulses are counted by a negedge monitor.
module tb_spi_slave_port;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  spi_slave_port_if #(.W(32)) bus ();

  spi_slave_port #(.W(32), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int n_dv  = 0;
  int n_ur  = 0;
  int n_ab  = 0;
  int s_dv, s_ur, s_ab;
  logic [31:0] mi;
  logic [31:0] mi2;

  // Count high cycles of each pulse output so a two-cycle pulse shows up as an extra count.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rx_dv)       n_dv++;
      if (bus.tx_underrun) n_ur++;
      if (bus.frame_abort) n_ab++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic snap();
    s_dv = n_dv;
    s_ur = n_ur;
    s_ab = n_ab;
  endtask

  task automatic load_word(input logic [31:0] v);
    @(negedge clk);
    bus.tx_data = v;
    bus.tx_load = 1'b1;
    @(negedge clk);
    bus.tx_load = 1'b0;
  endtask

  // nbits SCLK cycles MSB first; miso captured just before each rise; optional deselect with the last fall.
  task automatic xfer(input logic [31:0] mo, input int nbits, input bit end_cs, output logic [31:0] mso);
    mso = '0;
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = mo[31-i];
      repeat (8) @(negedge clk);
      mso = {mso[30:0], bus.miso};
      bus.sclk = 1'b1;
      repeat (8) @(negedge clk);
      bus.sclk = 1'b0;
      if (end_cs && i == nbits - 1) bus.cs_n = 1'b1;
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.sclk    = 1'b0;
    bus.cs_n    = 1'b1;
    bus.mosi    = 1'b0;
    bus.tx_data = '0;
    bus.tx_load = 1'b0;
    repeat (4) @(negedge clk);

    // Reset state
    check("rst_miso",    32'(bus.miso), 0);
    check("rst_dv",      32'(bus.rx_dv), 0);
    check("rst_pending", 32'(bus.tx_pending), 0);
    check("rst_ur",      32'(bus.tx_underrun), 0);
    check("rst_abort",   32'(bus.frame_abort), 0);
    check("rst_rxdata",  bus.rx_data, 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Basic frame
    load_word(32'hA5A50F0F);
    check("basic_pending_set", 32'(bus.tx_pending), 1);
    snap();
    bus.cs_n = 1'b0;
    xfer(32'hDEADBEEF, 32, 1'b1, mi);
    repeat (10) @(negedge clk);
    check("basic_miso_word", mi, 32'hA5A50F0F);
    check("basic_rx_data",   bus.rx_data, 32'hDEADBEEF);
    check("basic_dv_count",  32'(n_dv - s_dv), 1);
    check("basic_pending_clr", 32'(bus.tx_pending), 0);
    check("basic_ur_count",  32'(n_ur - s_ur), 0);
    check("basic_ab_count",  32'(n_ab - s_ab), 0);
    check("basic_idle_miso", 32'(bus.miso), 0);

    // Back-to-back frames under one chip select
    load_word(32'h12345678);
    snap();
    bus.cs_n = 1'b0;
    xfer(32'h00000001, 32, 1'b0, mi);
    check("b2b_rx_first", bus.rx_data, 32'h00000001);
    check("b2b_dv_first", 32'(n_dv - s_dv), 1);
    xfer(32'hFFFFFFFF, 32, 1'b1, mi2);
    repeat (10) @(negedge clk);
    check("b2b_miso_first",  mi,  32'h12345678);
    check("b2b_miso_second", mi2, 32'h00000000);
    check("b2b_rx_second",   bus.rx_data, 32'hFFFFFFFF);
    check("b2b_dv_count",    32'(n_dv - s_dv), 2);
    check("b2b_ur_count",    32'(n_ur - s_ur), 1);
    check("b2b_ab_count",    32'(n_ab - s_ab), 0);

    // Abort after 13 bits, then a clean frame
    snap();
    bus.cs_n = 1'b0;
    xfer(32'h87654321, 13, 1'b1, mi);
    repeat (10) @(negedge clk);
    check("abort_count",   32'(n_ab - s_ab), 1);
    check("abort_no_dv",   32'(n_dv - s_dv), 0);
    check("abort_rx_held", bus.rx_data, 32'hFFFFFFFF);
    check("abort_ur",      32'(n_ur - s_ur), 1);
    snap();
    bus.cs_n = 1'b0;
    xfer(32'hCAFEF00D, 32, 1'b1, mi);
    repeat (10) @(negedge clk);
    check("after_abort_rx",   bus.rx_data, 32'hCAFEF00D);
    check("after_abort_dv",   32'(n_dv - s_dv), 1);
    check("after_abort_ab",   32'(n_ab - s_ab), 0);
    check("after_abort_miso", mi, 32'h00000000);

    // Load collision in the exact LOAD cycle
    load_word(32'h11111111);
    snap();
    @(negedge clk);
    bus.cs_n = 1'b0;
    repeat (3) @(negedge clk);
    bus.tx_data = 32'h22222222;
    bus.tx_load = 1'b1;
    @(negedge clk);
    bus.tx_load = 1'b0;
    check("coll_pending_kept", 32'(bus.tx_pending), 1);
    xfer(32'h5A5A5A5A, 32, 1'b1, mi);
    repeat (10) @(negedge clk);
    check("coll_miso_old",    mi, 32'h11111111);
    check("coll_pending_mid", 32'(bus.tx_pending), 1);
    check("coll_rx",          bus.rx_data, 32'h5A5A5A5A);
    bus.cs_n = 1'b0;
    xfer(32'h600DF00D, 32, 1'b1, mi);
    repeat (10) @(negedge clk);
    check("coll_miso_new",     mi, 32'h22222222);
    check("coll_pending_done", 32'(bus.tx_pending), 0);
    check("coll_ur_count",     32'(n_ur - s_ur), 0);
    check("coll_rx2",          bus.rx_data, 32'h600DF00D);

    // Reset mid-frame: asynchronous clear, then a fresh frame
    load_word(32'h0F0F0F0F);
    bus.cs_n = 1'b0;
    xfer(32'hFFFF0000, 20, 1'b0, mi);
    load_word(32'h77777777);
    #2;
    rst = 1'b1;
    #1;
    check("arst_miso",    32'(bus.miso), 0);
    check("arst_dv",      32'(bus.rx_dv), 0);
    check("arst_pending", 32'(bus.tx_pending), 0);
    check("arst_ur",      32'(bus.tx_underrun), 0);
    check("arst_abort",   32'(bus.frame_abort), 0);
    check("arst_rxdata",  bus.rx_data, 32'h0);
    snap();
    bus.cs_n = 1'b1;
    bus.sclk = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    bus.cs_n = 1'b0;
    xfer(32'h3C3C5AA5, 32, 1'b1, mi);
    repeat (10) @(negedge clk);
    check("postrst_rx",   bus.rx_data, 32'h3C3C5AA5);
    check("postrst_dv",   32'(n_dv - s_dv), 1);
    check("postrst_ab",   32'(n_ab - s_ab), 0);
    check("postrst_ur",   32'(n_ur - s_ur), 1);
    check("postrst_miso", mi, 32'h00000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_port.md
# spi_slave_port

Responder (peripheral-side) end of the CPU's SPI link. It receives frames that the CPU-side SPI register block sends on MOSI and returns one word per frame on MISO. It oversamples the external SCLK, CS_N and MOSI pins in the system clock domain, deserializes W-bit MOSI frames into `rx_data` and serializes a CPU-visible transmit buffer onto MISO. Mode 0 only (CPOL=0, CPHA=0), MSB first.

## Interface
- `W`, 32 (`W_CPU`): frame and data width in bits.
- `SYNC_STAGES`, 2: flops in each pin synchronizer; minimum 2.

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `sclk`  in  1  SPI serial clock pin, asynchronous to `clk`.
- `cs_n`  in  1  chip select pin, active low, asynchronous.
- `mosi`  in  1  serial data in.
- `miso`  out  1  serial data out. Driven 0 when not selected; no tristate.
- `tx_data`  in  W  word to return in a later frame.
- `tx_load`  in  1  one-cycle strobe: capture `tx_data` into the transmit buffer.
- `tx_pending`  out  1  buffer holds a word not yet consumed by a frame.
- `rx_data`  out  W  last completed received word; held until the next completion.
- `rx_dv`  out  1  one-cycle pulse: `rx_data` just updated.
- `tx_underrun`  out  1  one-cycle pulse: frame started with no pending word; zeros were sent.
- `frame_abort`  out  1  one-cycle pulse: `cs_n` deasserted mid-frame.

## Operation
- `sclk`, `cs_n` and `mosi` each pass through a `SYNC_STAGES` synchronizer. One extra register per signal (`*_q`) gives edge detection.
- SCLK rise = `sclk_s & ~sclk_q`. SCLK fall = `~sclk_s & sclk_q`. Select = `~cs_s`.
- FSM states:
  - IDLE: `cs_s` high. `miso`=0, `bit_cnt`=0.
  - LOAD: one cycle, entered on the `cs_s` falling edge.
  - SHIFT: bit transfer in progress.
- Transitions:
  - IDLE→LOAD on the cs fall.
  - LOAD→SHIFT unconditionally.
  - SHIFT→LOAD on the falling SCLK edge after the W-th rising edge, if still selected.
  - Any state→IDLE when `cs_s` goes high.
- LOAD:
  - If `tx_pending`: `tx_shift`←`tx_buf`, clear `tx_pending`.
  - Otherwise: `tx_shift`←0 and pulse `tx_underrun`.
  - `miso`←`tx_shift[W-1]` from the cycle after LOAD, so the MSB is valid before the first SCLK rise.
- SHIFT, SCLK rise:
  - `rx_shift`←{`rx_shift[W-2:0]`, `mosi_s`}; `bit_cnt`++.
  - When `bit_cnt`==W-1: `rx_data`←{`rx_shift[W-2:0]`, `mosi_s`}, pulse `rx_dv`, `bit_cnt`←0, set `frame_end`.
- SHIFT, SCLK fall:
  - If `frame_end`: go to LOAD and clear `frame_end`. This supports back-to-back frames under one `cs_n`.
  - Otherwise: `tx_shift`←`tx_shift` << 1.
- `tx_load` sets `tx_buf`←`tx_data` and `tx_pending`←1 in any state.
  - If `tx_load` coincides with LOAD, LOAD consumes the old `tx_buf`. The new word is stored and `tx_pending` stays 1.
  - `tx_load` while `tx_pending` is already 1 overwrites the buffer silently.
- `cs_s` rising while `bit_cnt`≠0 or `frame_end`=0 in SHIFT:
  - Pulse `frame_abort` and discard `rx_shift`. No `rx_dv`.
  - The consumed tx word is lost. `rx_data` is unchanged.
  - A rise with `bit_cnt`=0 after a completed frame is a clean end: no abort.
- `cs_s` high overrides any same-cycle SCLK edge.
- Reset: all outputs 0, FSM IDLE, buffers and shift registers 0, `tx_pending`=0. A reset mid-frame discards the frame without pulses.

## Timing
- Pin-to-action latency is `SYNC_STAGES`+1 `clk` rising edges.
  - Example: MOSI sampled on the W-th SCLK pin rise gives `rx_dv` high in the 3rd `clk` cycle after that pin edge (`SYNC_STAGES`=2).
- Each SCLK high and low phase must last at least `SYNC_STAGES`+1 `clk` periods.
- `cs_n` falling to the first SCLK rise must be at least `SYNC_STAGES`+3 `clk` periods, to leave time for LOAD.
- `miso` updates `SYNC_STAGES`+1 cycles after an SCLK fall pin edge. The master samples on the next rise, so the half-period bound above guarantees setup.
- `rx_dv`, `tx_underrun` and `frame_abort` are exactly one `clk` cycle wide and registered.
- `tx_pending` falls the cycle after LOAD.

## Test plan
- **Reset:** assert `rst` mid-simulation → `miso`, `rx_dv`, `tx_pending`, `tx_underrun` and `frame_abort` are 0 and `rx_data`=0 immediately (asynchronous).
- **Basic frame:** `tx_load` 0xA5A50F0F, then `cs_n` low and 32 SCLK cycles (8 `clk` per half-period) with MOSI = 0xDEADBEEF MSB first →
  - MISO bits sampled on SCLK rises = 0xA5A50F0F.
  - `rx_data`=0xDEADBEEF with a single one-cycle `rx_dv`.
  - `tx_pending` 1→0.
- **Back-to-back frames:** one `tx_load` 0x12345678, 64 SCLK cycles under one `cs_n`, MOSI 0x00000001 then 0xFFFFFFFF →
  - Two `rx_dv` pulses with those values.
  - Second frame's MISO is all zero.
  - One `tx_underrun` pulse at the second LOAD.
- **Abort:** `cs_n` high after 13 bits → one `frame_abort` pulse, no `rx_dv`, `rx_data` unchanged. The next full frame with MOSI 0xCAFEF00D yields `rx_data`=0xCAFEF00D.
- **Load collision:** `tx_buf`=0x11111111 pending; `tx_load` 0x22222222 in the exact LOAD cycle → the frame sends 0x11111111, `tx_pending` stays 1, and the next frame sends 0x22222222.
- **Reset mid-frame:** `rst` after 20 bits, then release and run a full frame → no pulses from the broken frame, and the new frame is received correctly.
